// File: rtl/tex_quad_fetch.sv
// Texel-quad gather: turns one fixed-point coordinate into four in-order cache reads and a filter bundle.
// Define TEX_CLAMP_EN for clamp-to-edge addressing; otherwise coordinates wrap (repeat addressing).
module tex_quad_fetch #(
  parameter int FRAC    = 8,
  parameter int TW_LOG2 = 8,
  parameter int TH_LOG2 = 8,
  parameter int ADDR_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [TW_LOG2+FRAC-1:0]   u_in,
  input  logic [TH_LOG2+FRAC-1:0]   v_in,
  input  logic [ADDR_W-1:0]         tex_base,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic [ADDR_W-1:0]         mem_req_addr,
  input  logic                      mem_rsp_valid,
  input  logic [31:0]               mem_rsp_data,
  output logic [31:0]               tex00,
  output logic [31:0]               tex10,
  output logic [31:0]               tex01,
  output logic [31:0]               tex11,
  output logic [FRAC-1:0]           u_frac,
  output logic [FRAC-1:0]           v_frac,
  output logic                      out_valid
);

  localparam int UW = TW_LOG2 + FRAC;
  localparam int VW = TH_LOG2 + FRAC;
  localparam logic [UW-1:0] HALF_U = UW'(1) << (FRAC - 1);
  localparam logic [VW-1:0] HALF_V = VW'(1) << (FRAC - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

  state_t               state, state_nxt;
  logic [2:0]           iss_p0;
  logic [1:0]           rc_p0;
  logic [ADDR_W-1:0]    base_p0;
  logic [TW_LOG2-1:0]   x0_p0, x1_p0;
  logic [TH_LOG2-1:0]   y0_p0, y1_p0;
  logic [FRAC-1:0]      uf_p0, vf_p0;
  logic [31:0]          slot0_p0, slot1_p0, slot2_p0;
  logic [TW_LOG2-1:0]   xsel;
  logic [TH_LOG2-1:0]   ysel;
  logic                 accept;
  logic                 last_rsp;

  // Centre-offset a coordinate and split it into {second texel, first texel, weight}.
  function automatic logic [2*TW_LOG2+FRAC-1:0] split_u(input logic [UW-1:0] c);
    logic [UW-1:0]      s;
    logic [TW_LOG2-1:0] a0, a1;
    logic [FRAC-1:0]    f;
    s  = c - HALF_U;
    a0 = s[UW-1:FRAC];
    f  = s[FRAC-1:0];
    a1 = a0 + TW_LOG2'(1);
`ifdef TEX_CLAMP_EN
    if (c < HALF_U) begin
      a0 = '0;
      a1 = '0;
      f  = '0;
    end else if (&a0) begin
      a1 = a0;
    end
`endif
    return {a1, a0, f};
  endfunction

  function automatic logic [2*TH_LOG2+FRAC-1:0] split_v(input logic [VW-1:0] c);
    logic [VW-1:0]      s;
    logic [TH_LOG2-1:0] a0, a1;
    logic [FRAC-1:0]    f;
    s  = c - HALF_V;
    a0 = s[VW-1:FRAC];
    f  = s[FRAC-1:0];
    a1 = a0 + TH_LOG2'(1);
`ifdef TEX_CLAMP_EN
    if (c < HALF_V) begin
      a0 = '0;
      a1 = '0;
      f  = '0;
    end else if (&a0) begin
      a1 = a0;
    end
`endif
    return {a1, a0, f};
  endfunction

  always_comb begin
    state_nxt     = state;
    req_ready     = 1'b0;
    mem_req_valid = 1'b0;
    out_valid     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = FETCH;
      end
      FETCH: begin
        mem_req_valid = ~iss_p0[2];
        if (mem_rsp_valid && rc_p0 == 2'd3) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept   = req_valid & req_ready;
  assign last_rsp = (state == FETCH) & mem_rsp_valid & (rc_p0 == 2'd3);

  // Issue order (x0,y0),(x1,y0),(x0,y1),(x1,y1): bit 0 picks x, bit 1 picks y.
  always_comb begin
    xsel         = iss_p0[0] ? x1_p0 : x0_p0;
    ysel         = iss_p0[1] ? y1_p0 : y0_p0;
    mem_req_addr = '0;
    if (mem_req_valid) mem_req_addr = base_p0 + ADDR_W'({ysel, xsel});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      iss_p0 <= '0;
      rc_p0  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        iss_p0 <= '0;
        rc_p0  <= '0;
      end else if (state == FETCH) begin
        if (mem_req_valid && mem_req_ready) iss_p0 <= iss_p0 + 3'd1;
        if (mem_rsp_valid) rc_p0 <= rc_p0 + 2'd1;
      end
    end
  end

  // Accept stage: footprint and weights latched once per request; slots collect responses.
  always_ff @(posedge clk) begin
    if (accept) begin
      base_p0                  <= tex_base;
      {x1_p0, x0_p0, uf_p0}    <= split_u(u_in);
      {y1_p0, y0_p0, vf_p0}    <= split_v(v_in);
    end
    if (state == FETCH && mem_rsp_valid) begin
      case (rc_p0)
        2'd0:    slot0_p0 <= mem_rsp_data;
        2'd1:    slot1_p0 <= mem_rsp_data;
        2'd2:    slot2_p0 <= mem_rsp_data;
        default: ;
      endcase
    end
  end

  // Output stage: bundle changes only when the fourth texel lands; the fourth goes straight through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tex00  <= '0;
      tex10  <= '0;
      tex01  <= '0;
      tex11  <= '0;
      u_frac <= '0;
      v_frac <= '0;
    end else if (last_rsp) begin
      tex00  <= slot0_p0;
      tex10  <= slot1_p0;
      tex01  <= slot2_p0;
      tex11  <= mem_rsp_data;
      u_frac <= uf_p0;
      v_frac <= vf_p0;
    end
  end

endmodule

// File: tb/tb_tex_quad_fetch.sv
// Scoreboard bench for tex_quad_fetch with a cache model and an integer reference of the footprint rules.
module tb_tex_quad_fetch;
  localparam int FRAC = 8;
  localparam int TWL  = 8;
  localparam int THL  = 8;
  localparam int AW   = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [TWL+FRAC-1:0] u_in = '0;
  logic [THL+FRAC-1:0] v_in = '0;
  logic [AW-1:0]     tex_base = '0;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [AW-1:0]     mem_req_addr;
  logic              mem_rsp_valid;
  logic [31:0]       mem_rsp_data;
  logic [31:0]       tex00, tex10, tex01, tex11;
  logic [FRAC-1:0]   u_frac, v_frac;
  logic              out_valid;

  tex_quad_fetch #(.FRAC(FRAC), .TW_LOG2(TWL), .TH_LOG2(THL), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .u_in(u_in), .v_in(v_in), .tex_base(tex_base),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .tex00(tex00), .tex10(tex10), .tex01(tex01), .tex11(tex11),
    .u_frac(u_frac), .v_frac(v_frac), .out_valid(out_valid)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [31:0] t00, t10, t01, t11;
    logic [7:0]  uf, vf;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] addr_q[$];
  logic [31:0] pend_d[$];
  int          pend_due[$];
  int          gap_q[$];
  exp_t        last_exp;

  int checks = 0, failures = 0;
  int cyc = 0, epoch = 0, hs_idx = 0, acc_cyc = 0;
  int stall_idx = -1, stall_len = 0, stalled = 0;
  int rsp_lat = 1, rand_mode = 0, rsp_cnt = 0, done_cnt = 0, gap_w = 0;
  bit spur = 1'b0;
  bit held_v = 1'b0;
  logic [31:0] held_a = '0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Texel data depends on address and on which request asked for it, so stale words are recognisable.
  function automatic logic [31:0] mk(input logic [31:0] a, input int ep);
    return (a * 32'h9E37_79B1) ^ (32'(ep) << 24) ^ 32'h00A5_0000;
  endfunction

  function automatic void split(input int c, input int tlog, output int a0, output int a1, output int f);
    int modv, n, s;
    modv = 1 << (tlog + FRAC);
    n    = 1 << tlog;
    s    = (c - (1 << (FRAC - 1)) + modv) % modv;
    a0   = s / (1 << FRAC);
    f    = s % (1 << FRAC);
    a1   = (a0 + 1) % n;
`ifdef TEX_CLAMP_EN
    if (c < (1 << (FRAC - 1))) begin
      a0 = 0; a1 = 0; f = 0;
    end else if (a0 == n - 1) begin
      a1 = a0;
    end
`endif
  endfunction

  // Cache model: ready policy, address check per handshake, in-order responses with latency and gaps.
  initial begin
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (mem_req_valid && hs_idx == stall_idx && stalled < stall_len) begin
        mem_req_ready = 1'b0;
        stalled++;
      end else begin
        mem_req_ready = rand_mode != 0 ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      if (mem_req_valid && !mem_req_ready) begin
        if (held_v) chk("addr_hold", mem_req_addr, held_a);
        held_a = mem_req_addr;
        held_v = 1'b1;
      end else begin
        held_v = 1'b0;
      end
      if (mem_req_valid && mem_req_ready) begin
        if (addr_q.size() == 0) chk("unexpected_handshake", 1, 0);
        else chk("mem_req_addr", mem_req_addr, addr_q.pop_front());
        pend_d.push_back(mk(mem_req_addr, epoch));
        pend_due.push_back(cyc + (rand_mode != 0 ? int'($urandom_range(1, 4)) : rsp_lat));
        hs_idx++;
      end
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = $urandom;
      if (spur) begin
        mem_rsp_valid = 1'b1;
        spur = 1'b0;
      end else if (gap_w > 0) begin
        gap_w--;
      end else if (pend_d.size() > 0 && pend_due[0] <= cyc) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = pend_d.pop_front();
        void'(pend_due.pop_front());
        rsp_cnt++;
        if (gap_q.size() > 0) gap_w = gap_q.pop_front();
        else gap_w = rand_mode != 0 ? int'($urandom_range(0, 2)) : 0;
      end
    end
  end

  // Monitor: every out_valid pulse consumes one expected bundle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("tex00", tex00, e.t00);
          chk("tex10", tex10, e.t10);
          chk("tex01", tex01, e.t01);
          chk("tex11", tex11, e.t11);
          chk("u_frac", u_frac, e.uf);
          chk("v_frac", v_frac, e.vf);
          if (e.lat >= 0) chk("out_latency", cyc - acc_cyc, e.lat);
        end
        done_cnt++;
      end
    end
  end

  task automatic issue_req(input logic [15:0] u, input logic [15:0] v, input logic [31:0] base, input int lat);
    int x0, x1, y0, y1, uf, vf, w;
    logic [31:0] a [4];
    exp_t e;
    w = 0;
    @(negedge clk);
    while (!req_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) chk("req_ready_timeout", 0, 1);
    split(int'(u), TWL, x0, x1, uf);
    split(int'(v), THL, y0, y1, vf);
    a[0] = base + 32'(y0 * (1 << TWL) + x0);
    a[1] = base + 32'(y0 * (1 << TWL) + x1);
    a[2] = base + 32'(y1 * (1 << TWL) + x0);
    a[3] = base + 32'(y1 * (1 << TWL) + x1);
    epoch++;
    hs_idx  = 0;
    stalled = 0;
    for (int i = 0; i < 4; i++) addr_q.push_back(a[i]);
    e.t00 = mk(a[0], epoch);
    e.t10 = mk(a[1], epoch);
    e.t01 = mk(a[2], epoch);
    e.t11 = mk(a[3], epoch);
    e.uf  = 8'(uf);
    e.vf  = 8'(vf);
    e.lat = lat;
    exp_q.push_back(e);
    last_exp  = e;
    req_valid = 1'b1;
    u_in      = u;
    v_in      = v;
    tex_base  = base;
    acc_cyc   = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    u_in      = 16'($urandom);
    v_in      = 16'($urandom);
    tex_base  = $urandom;
  endtask

  task automatic wait_done(input int start);
    int w;
    w = 0;
    while (done_cnt == start && w < 400) begin
      @(negedge clk);
      w++;
    end
    if (done_cnt == start) chk("done_timeout", 0, 1);
  endtask

  task automatic do_req(input logic [15:0] u, input logic [15:0] v, input logic [31:0] base, input int lat);
    int start;
    start = done_cnt;
    issue_req(u, v, base, lat);
    wait_done(start);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_mem_req_valid"}, mem_req_valid, 0);
    chk({tag, "_mem_req_addr"}, mem_req_addr, 0);
    chk({tag, "_tex00"}, tex00, 0);
    chk({tag, "_tex10"}, tex10, 0);
    chk({tag, "_tex01"}, tex01, 0);
    chk({tag, "_tex11"}, tex11, 0);
    chk({tag, "_u_frac"}, u_frac, 0);
    chk({tag, "_v_frac"}, v_frac, 0);
    chk({tag, "_req_ready"}, req_ready, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int start, w;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Nominal: accept at 0, out_valid at 6.
    rsp_lat = 1;
    do_req(16'h0A80, 16'h05C0, 32'h1000, 6);
    // Left wrap and top-edge wrap under repeat (clamp under TEX_CLAMP_EN).
    do_req(16'h0040, 16'h0080, 32'h1000, 6);
    do_req(16'hFFC0, 16'hFFC0, 32'h1000, 6);
    do_req(16'h0040, 16'hFFC0, 32'h1000, 6);

    // Backpressure: second request held for three cycles.
    stall_idx = 1;
    stall_len = 3;
    do_req(16'h0A80, 16'h05C0, 32'h1000, 9);
    chk("handshakes", hs_idx, 4);
    stall_idx = -1;
    stall_len = 0;

    // Responses bunched after all requests: cycles 6,7,10,16, so out_valid at 17.
    rsp_lat = 5;
    gap_q.push_back(0);
    gap_q.push_back(2);
    gap_q.push_back(5);
    do_req(16'h3377, 16'h1199, 32'h1000, 17);
    rsp_lat = 1;

    // Spurious response while idle leaves the bundle alone.
    repeat (3) @(negedge clk);
    spur = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_tex00", tex00, last_exp.t00);
    chk("idle_tex11", tex11, last_exp.t11);
    chk("idle_u_frac", u_frac, last_exp.uf);
    chk("idle_v_frac", v_frac, last_exp.vf);

    // Reset after two responses; the stale remainder lands while idle.
    start = rsp_cnt;
    issue_req(16'h0A80, 16'h05C0, 32'h2000, 6);
    w = 0;
    while (rsp_cnt < start + 2 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (rsp_cnt < start + 2) chk("rsp_timeout", 0, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    addr_q.delete();
    chk_zero("midreset");
    #1 rst_n = 1'b1;
    w = 0;
    while (pend_d.size() > 0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    repeat (3) @(negedge clk);
    chk_zero("after_stale");
    do_req(16'h0A80, 16'h05C0, 32'h2000, 6);

    // Randomized traffic with random ready, latency and gaps.
    rand_mode = 1;
    for (int i = 0; i < 25; i++)
      do_req(16'($urandom), 16'($urandom), $urandom, -1);
    rand_mode = 0;

    repeat (10) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("addr_q_drained", addr_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
